// File: rtl/ucode_seq_if.sv
// Bus/fetch-side and datapath-side signals of the microcode sequencer.
// The master drives bus handshake and table writes; the slave (sequencer) drives control outputs.
interface ucode_seq_if #(
  parameter int OP_BITS   = 8,
  parameter int CYC_BITS  = 6,
  parameter int X_BITS    = 12,
  parameter int SLOT_BITS = 3
);
  logic                 rdy;
  logic [OP_BITS-1:0]   din;
  logic                 go;
  logic                 tbl_we;
  logic [OP_BITS-1:0]   tbl_op;
  logic [SLOT_BITS-1:0] tbl_slot;
  logic [X_BITS-1:0]    tbl_data;
  logic [X_BITS-1:0]    x;
  logic [OP_BITS-1:0]   ir;
  logic [CYC_BITS-1:0]  cycle;
  logic                 sync;
  logic                 loading;
  logic                 trap;
  logic [1:0]           trap_cause;

  modport master (
    output rdy, din, go, tbl_we, tbl_op, tbl_slot, tbl_data,
    input  x, ir, cycle, sync, loading, trap, trap_cause
  );

  modport slave (
    input  rdy, din, go, tbl_we, tbl_op, tbl_slot, tbl_data,
    output x, ir, cycle, sync, loading, trap, trap_cause
  );
endinterface

// File: rtl/ucode_seq.sv
// Run-time loadable microcode sequencer: instruction register, one-hot cycle counter
// and a writable {opcode, slot} control-word table with per-entry valid bits.
module ucode_seq #(
  parameter int OP_BITS   = 8,
  parameter int CYC_BITS  = 6,
  parameter int X_BITS    = 12,
  parameter int NEXT_BIT  = 0,
  parameter int SLOT_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  ucode_seq_if.slave bus
);

  localparam int SLOTS    = CYC_BITS + 1;
  localparam int ENTRIES  = (2 ** OP_BITS) * SLOTS;
  localparam int IDX_BITS = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OP_BITS-1:0]  ir_q, ir_d;
  logic [CYC_BITS-1:0] cycle_q, cycle_d;
  logic [1:0]          cause_q, cause_d;

  logic [X_BITS-1:0]   tbl_mem [ENTRIES];
  logic [ENTRIES-1:0]  valid_q;

  logic [SLOT_BITS-1:0] cur_slot;
  logic [IDX_BITS-1:0]  rd_idx, wr_idx;
  logic                 wr_en;
  logic                 entry_valid;
  logic [X_BITS-1:0]    x_int;
  logic                 sync_int;

  // Slot 0 is C_N (no bit set); C_k maps to slot k+1.
  always_comb begin
    cur_slot = '0;
    for (int k = 0; k < CYC_BITS; k++) begin
      if (cycle_q[k]) cur_slot = SLOT_BITS'(k + 1);
    end
  end

  assign rd_idx = IDX_BITS'(ir_q) * IDX_BITS'(SLOTS) + IDX_BITS'(cur_slot);
  assign wr_idx = IDX_BITS'(bus.tbl_op) * IDX_BITS'(SLOTS) + IDX_BITS'(bus.tbl_slot);
  assign wr_en  = (state_q == S_LOAD) && bus.tbl_we &&
                  (bus.tbl_slot <= SLOT_BITS'(CYC_BITS));
  assign entry_valid = valid_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) tbl_mem[wr_idx] <= bus.tbl_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      ir_q    <= '0;
      cycle_q <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cycle_q <= cycle_d;
      cause_q <= cause_d;
    end
  end

  // An invalid entry traps even while the bus is stalled.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cycle_d  = cycle_q;
    cause_d  = cause_q;
    x_int    = '0;
    sync_int = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (bus.go) begin
          state_d = S_RUN;
          ir_d    = '0;
          cycle_d = '0;
        end
      end
      S_RUN: begin
        if (!entry_valid) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          x_int = tbl_mem[rd_idx];
          if (bus.rdy) begin
            if (x_int[NEXT_BIT]) begin
              sync_int = 1'b1;
              ir_d     = bus.din;
              cycle_d  = CYC_BITS'(1);
            end else if (cycle_q == '0) begin
              cycle_d = CYC_BITS'(1);
            end else if (cycle_q[CYC_BITS-1]) begin
              state_d = S_TRAP;
              cause_d = 2'b10;
            end else begin
              cycle_d = cycle_q << 1;
            end
          end
        end
      end
      S_TRAP: begin
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign bus.x          = x_int;
  assign bus.ir         = ir_q;
  assign bus.cycle      = cycle_q;
  assign bus.sync       = sync_int;
  assign bus.loading    = (state_q == S_LOAD);
  assign bus.trap       = (state_q == S_TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq: directed scenarios plus randomized programs,
// all compared each cycle against a table/step-count reference model.
module tb_ucode_seq;

  localparam int OP  = 8;
  localparam int CYC = 6;
  localparam int XB  = 12;
  localparam int NB  = 0;
  localparam int SB  = 3;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRAP = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ucode_seq_if #(.OP_BITS(OP), .CYC_BITS(CYC), .X_BITS(XB), .SLOT_BITS(SB)) bus ();

  ucode_seq #(
    .OP_BITS(OP), .CYC_BITS(CYC), .X_BITS(XB), .NEXT_BIT(NB), .SLOT_BITS(SB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, opcode, and position counted in slots (0 = C_N, k+1 = C_k).
  int              m_mode, m_ir, m_slot, m_cause;
  logic [XB-1:0]   m_data  [256][CYC+1];
  bit              m_valid [256][CYC+1];

  logic [XB-1:0]   t1_x   [4] = '{12'h001, 12'h002, 12'h00A, 12'hC01};
  logic [CYC-1:0]  t1_cyc [4] = '{6'b000000, 6'b000001, 6'b000010, 6'b000100};
  int              ops [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XB-1:0] expX();
    if (m_mode == M_RUN && m_valid[m_ir][m_slot]) return m_data[m_ir][m_slot];
    return '0;
  endfunction

  task automatic modelReset();
    m_mode  = M_LOAD;
    m_ir    = 0;
    m_slot  = 0;
    m_cause = 0;
    foreach (m_valid[i, j]) m_valid[i][j] = 1'b0;
  endtask

  task automatic modelEdge();
    if (reset) begin
      modelReset();
      return;
    end
    case (m_mode)
      M_LOAD: begin
        if (bus.tbl_we && int'(bus.tbl_slot) <= CYC) begin
          m_data[bus.tbl_op][bus.tbl_slot]  = bus.tbl_data;
          m_valid[bus.tbl_op][bus.tbl_slot] = 1'b1;
        end
        if (bus.go) begin
          m_mode = M_RUN;
          m_ir   = 0;
          m_slot = 0;
        end
      end
      M_RUN: begin
        if (!m_valid[m_ir][m_slot]) begin
          m_mode  = M_TRAP;
          m_cause = 1;
        end else if (bus.rdy) begin
          if (m_data[m_ir][m_slot][NB]) begin
            m_ir   = int'(bus.din);
            m_slot = 1;
          end else if (m_slot == CYC) begin
            m_mode  = M_TRAP;
            m_cause = 2;
          end else begin
            m_slot++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string tag);
    logic [XB-1:0]  ex;
    logic [CYC-1:0] ec;
    ex = expX();
    ec = (m_slot == 0) ? '0 : CYC'(1 << (m_slot - 1));
    check({tag, ".x"},          bus.x,          ex);
    check({tag, ".ir"},         bus.ir,         m_ir);
    check({tag, ".cycle"},      bus.cycle,      ec);
    check({tag, ".sync"},       bus.sync,       (m_mode == M_RUN) && ex[NB] && bus.rdy);
    check({tag, ".loading"},    bus.loading,    m_mode == M_LOAD);
    check({tag, ".trap"},       bus.trap,       m_mode == M_TRAP);
    check({tag, ".trap_cause"}, bus.trap_cause, m_cause);
  endtask

  task automatic applyStimulus(input bit rdy, input int din, input bit go,
                               input bit we = 1'b0, input int op = 0,
                               input int slot = 0, input int data = 0);
    bus.rdy      = rdy;
    bus.din      = OP'(din);
    bus.go       = go;
    bus.tbl_we   = we;
    bus.tbl_op   = OP'(op);
    bus.tbl_slot = SB'(slot);
    bus.tbl_data = XB'(data);
  endtask

  task automatic step(input string tag);
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic runCycle(input string tag, input bit rdy, input int din, input bit go,
                          input bit we = 1'b0, input int op = 0,
                          input int slot = 0, input int data = 0);
    applyStimulus(rdy, din, go, we, op, slot, data);
    step(tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    applyStimulus(1'b0, 0, 1'b0);
    step("reset");
    reset = 1'b0;
  endtask

  task automatic loadJmp();
    runCycle("load", 0, 0, 0, 1, 8'h00, 0, 12'h001);
    runCycle("load", 0, 0, 0, 1, 8'h4C, 1, 12'h002);
    runCycle("load", 0, 0, 0, 1, 8'h4C, 2, 12'h00A);
    runCycle("load", 0, 0, 0, 1, 8'h4C, 3, 12'hC01);
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // Basic program: op 0 fetches 0x4C, which runs three words.
    loadJmp();
    runCycle("go", 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'h4C, 0);
      #1;
      check("t1.x_lit", bus.x, t1_x[i]);
      check("t1.cycle_lit", bus.cycle, t1_cyc[i]);
      check("t1.sync_lit", bus.sync, (i == 0 || i == 3));
      step("t1");
    end

    // Stall in C_1, then fetch an opcode with no table entries.
    runCycle("t2", 1, 8'h4C, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'h4C, 0);
      #1;
      check("t2.x_hold", bus.x, 12'h00A);
      check("t2.cycle_hold", bus.cycle, 6'b000010);
      step("t2");
    end
    runCycle("t2", 1, 8'h4C, 0);
    runCycle("t2", 1, 8'hEA, 0);
    applyStimulus(0, 0, 0);
    #1;
    check("t3.x_undef", bus.x, 0);
    step("t3");
    check("t3.trap", bus.trap, 1);
    check("t3.cause", bus.trap_cause, 2'b01);
    check("t3.ir", bus.ir, 8'hEA);
    check("t3.cycle", bus.cycle, 6'b000001);
    runCycle("t3.frozen", 1, 0, 1, 1, 8'hEA, 1, 12'h001);
    runCycle("t3.frozen", 1, 0, 1);

    // Overflow: op 0x11 never ends its instruction.
    doReset();
    runCycle("load", 0, 0, 0, 1, 8'h00, 0, 12'h001);
    for (int s = 0; s <= CYC; s++)
      runCycle("load", 0, 0, 0, 1, 8'h11, s, ($urandom_range(1, 4095) & 12'hFFE) | 12'h010);
    runCycle("load.bad_slot", 0, 0, 0, 1, 8'h11, 7, 12'h001);
    runCycle("go", 0, 0, 1);
    for (int i = 0; i < 10; i++) runCycle("t4", 1, 8'h11, 0);
    check("t4.cause", bus.trap_cause, 2'b10);
    check("t4.cycle", bus.cycle, 6'b100000);
    check("t4.ir", bus.ir, 8'h11);

    // Table writes during RUN are ignored.
    doReset();
    runCycle("load", 0, 0, 0, 1, 8'h00, 0, 12'h001);
    runCycle("go", 0, 0, 1);
    runCycle("t5", 1, 8'hA9, 1, 1, 8'hA9, 1, 12'h003);
    applyStimulus(1, 0, 0);
    #1;
    check("t5.x", bus.x, 0);
    step("t5");
    check("t5.cause", bus.trap_cause, 2'b01);
    check("t5.ir", bus.ir, 8'hA9);

    // Reset mid-instruction clears valid bits.
    doReset();
    loadJmp();
    runCycle("go", 0, 0, 1);
    for (int i = 0; i < 3; i++) runCycle("t6", 1, 8'h4C, 0);
    check("t6.cycle_c2", bus.cycle, 6'b000100);
    reset = 1'b1;
    modelReset();
    applyStimulus(1, 8'h4C, 0);
    #1;
    check("t6.loading", bus.loading, 1);
    check("t6.x", bus.x, 0);
    step("t6.reset");
    reset = 1'b0;
    runCycle("t6.go", 1, 0, 1);
    runCycle("t6", 1, 0, 0);
    check("t6.cause", bus.trap_cause, 2'b01);
    check("t6.ir", bus.ir, 0);

    // Randomized programs over a small opcode set.
    for (int r = 0; r < 8; r++) begin
      doReset();
      ops[0] = 0;
      for (int k = 1; k < 4; k++) ops[k] = $urandom_range(1, 255);
      for (int k = 0; k < 4; k++) begin
        for (int s = 0; s <= 7; s++) begin
          if ($urandom_range(0, 9) < 8) begin
            int d;
            d = $urandom_range(0, 4095) & 12'hFFE;
            if ($urandom_range(0, 2) == 0) d = d | 1;
            runCycle("rload", 0, 0, 0, 1, ops[k], s, d);
          end
        end
      end
      runCycle("rgo", 0, 0, 1, $urandom_range(0, 1), ops[0], 0, 12'h001);
      for (int c = 0; c < 40; c++) begin
        runCycle("rand", $urandom_range(0, 3) != 0, ops[$urandom_range(0, 3)],
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 ops[$urandom_range(0, 3)], $urandom_range(0, 7),
                 $urandom_range(0, 4095));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
Name: ucode_seq

Overview:
Parametrised, run-time loadable microcode sequencer for the k6502 core. It succeeds the fixed {ir, cycle} decode ROM. It holds the instruction register and the one-hot cycle counter, and looks up the control word from a writable table. It advances on a bus-ready handshake and traps on undefined entries or cycle overflow. It sits between the bus/fetch logic and the datapath and drives the datapath control word x.

Parameters:
OP_BITS, 8, opcode width; table holds 2**OP_BITS opcodes.
CYC_BITS, 6, one-hot cycle counter width (C_0..C_{CYC_BITS-1}); C_N = all zeros.
X_BITS, 12, control word width.
NEXT_BIT, 0, bit of the control word that ends the instruction (fetch next opcode).
SLOT_BITS, 3, slot index width; must satisfy 2**SLOT_BITS >= CYC_BITS+1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
rdy  in  1  bus ready; sequencer advances only when high.
din  in  OP_BITS  data bus; captured as the opcode on an instruction boundary.
go  in  1  single-cycle pulse; LOAD -> RUN.
tbl_we  in  1  table write strobe; honoured in LOAD only.
tbl_op  in  OP_BITS  opcode index of the write.
tbl_slot  in  SLOT_BITS  slot of the write: 0 = C_N; s>=1 = C_{s-1}.
tbl_data  in  X_BITS  control word to store.
x  out  X_BITS  current control word.
ir  out  OP_BITS  current opcode.
cycle  out  CYC_BITS  current one-hot cycle.
sync  out  1  high when the current word has NEXT_BIT set, rdy=1, and state=RUN.
loading  out  1  high in LOAD.
trap  out  1  high in TRAP.
trap_cause  out  2  00 none, 01 undefined entry, 10 cycle overflow.

Behaviour:
- Reset (async, any state, including mid-instruction or mid-load):
  - state=LOAD; ir=0; cycle=0 (C_N); trap=0; trap_cause=00.
  - All table valid bits cleared; table data not reset.
  - x=0; sync=0; loading=1.
- Table: (2**OP_BITS) x (CYC_BITS+1) entries of X_BITS, each with a valid bit.
  - Write: when tbl_we=1 in LOAD with tbl_slot <= CYC_BITS, the entry is written and its valid bit set at the edge.
  - Ignored otherwise: writes outside LOAD, or with tbl_slot > CYC_BITS.
  - A rewrite overwrites the entry.
- State LOAD: x=0. go=1 -> RUN at the next edge with ir=0, cycle=C_N. If tbl_we and go are high in the same cycle, the write takes effect and RUN is entered.
- State RUN:
  - Lookup: entry(ir, slot(cycle)) is combinational; x = entry data if valid, else 0.
  - Entry invalid: -> TRAP at the next edge regardless of rdy; trap_cause=01.
  - Entry valid, rdy=0: all state held; x stable.
  - Entry valid, rdy=1, x[NEXT_BIT]=1: ir<=din; cycle<=C_0. Holds for every cycle, including C_N.
  - Entry valid, rdy=1, x[NEXT_BIT]=0:
    - cycle=C_N -> C_0, ir unchanged.
    - cycle=C_k with k<CYC_BITS-1 -> C_{k+1}.
    - cycle=C_{CYC_BITS-1} -> TRAP; trap_cause=10.
- State TRAP: x=0; sync=0; ir and cycle frozen at the faulting values. Only reset exits; go and tbl_we are ignored.
- go outside LOAD is ignored.
- Latency:
  - x reflects a new (ir, cycle) combinationally in the same cycle they are registered.
  - An opcode on din at the sync edge produces its C_0 word in the following cycle.

Test Plan:
- Reset, load (0,slot0)=0x001, (0x4C,s1)=0x002, (0x4C,s2)=0x00A, (0x4C,s3)=0xC01, go, rdy=1, din=0x4C at the sync edge.
  -> x sequence 0x001, 0x002, 0x00A, 0xC01; sync pulses on the first and last; cycle 000000, 000001, 000010, 000100.
- Same program with rdy=0 for 3 cycles during C_1.
  -> x=0x00A and cycle=000010 held 4 cycles; completes identically afterwards.
- Opcode 0xEA fetched with no entries written.
  -> x=0 in C_0; next edge trap=1, trap_cause=01, ir=0xEA, cycle=000001.
- Opcode 0x11 with all 7 slots written, NEXT_BIT=0 in every slot.
  -> walks C_N..C_5; edge after C_5 gives trap_cause=10, cycle=100000.
- tbl_we pulsed in RUN for (0xA9,s1), then 0xA9 fetched.
  -> write ignored; trap_cause=01 in C_0.
- Reset asserted mid-instruction at C_2, then go without reload.
  -> loading=1, x=0 during reset; after go, the C_N entry is invalid and trap_cause=01 with ir=0.
